ifetch_align: RTL and testbench



---
 rtl/ifetch_align_pkg.sv | 44 ++++
 rtl/ifetch_align_hwq.sv | 92 +++++++++
 rtl/ifetch_align.sv | 171 +++++++++++++++++
 tb/tb_ifetch_align.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_align_pkg.sv
// ----------------------------------------------------------------------------
// Shared definitions for the instruction realigner.
//
//   trap_causes  : fetch-side exception cause codes.
//   ifetch_types : instruction/address widths and the halfword queue entry
//                  type (ifetch_hw_t) plus a small constructor helper.
//
// Configuration macro used by the realigner: ISA_C_EN (compressed ISA).
// Nothing in this file depends on it.
// ----------------------------------------------------------------------------

package trap_causes;

    localparam logic [3:0] EXC_INSTR_ADDR_MISALIGNED = 4'd0;
    localparam logic [3:0] EXC_INSTR_ACCESS_FAULT    = 4'd1;
    localparam logic [3:0] EXC_INSTR_PAGE_FAULT      = 4'd12;

endpackage : trap_causes

package ifetch_types;

    localparam int ILEN = 32;
    localparam int ALEN = 32;

    // One buffered halfword with the fault status of the word it came from.
    typedef struct packed {
        logic [15:0] data;
        logic        exc;
        logic [3:0]  cause;
    } ifetch_hw_t;

    function automatic ifetch_hw_t make_hw(
        input logic [15:0] data,
        input logic        exc,
        input logic [3:0]  cause
    );
        ifetch_hw_t hw;
        hw.data  = data;
        hw.exc   = exc;
        hw.cause = cause;
        return hw;
    endfunction

endpackage : ifetch_types

// File: rtl/ifetch_align_hwq.sv
// ----------------------------------------------------------------------------
// ifetch_align_hwq : 3-entry halfword queue for the instruction realigner.
//
// Entry 0 is always the head. A pop removes 0/1/2 entries from the head and a
// push appends 0/1/2 entries behind whatever survives the pop, all in the same
// cycle. The caller guarantees it never pops more than it holds and never
// pushes beyond three entries.
//
// Ports:
//   clk        : clock
//   rst_i      : synchronous active-high reset (empties the queue)
//   clear_i    : synchronous clear (pipeline redirect), same effect as reset
//   push_n_i   : number of halfwords to append (0..2)
//   push_hw0_i : first halfword appended
//   push_hw1_i : second halfword appended (used when push_n_i == 2)
//   pop_n_i    : number of halfwords to remove from the head (0..2)
//   count_o    : current occupancy (0..3)
//   head0_o    : entry 0 (head)
//   head1_o    : entry 1
//
// Configuration macro of the enclosing block: ISA_C_EN (not used here).
// ----------------------------------------------------------------------------

module ifetch_align_hwq
    import ifetch_types::*;
(
    input  logic       clk,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic [1:0] push_n_i,
    input  ifetch_hw_t push_hw0_i,
    input  ifetch_hw_t push_hw1_i,
    input  logic [1:0] pop_n_i,
    output logic [1:0] count_o,
    output ifetch_hw_t head0_o,
    output ifetch_hw_t head1_o
);

    logic [1:0]       count_q;
    logic [2:0]       count_d;
    logic [2:0]       base;
    ifetch_hw_t [2:0] entries_q;
    ifetch_hw_t [2:0] entries_d;
    ifetch_hw_t [2:0] shifted;

    // Occupancy left after the pop; new halfwords land at this slot.
    assign base    = {1'b0, count_q} - {1'b0, pop_n_i};
    assign count_d = base + {1'b0, push_n_i};

    // Queue contents after removing pop_n_i entries from the head. Slots past
    // the survivors are filled with stale data; they are either overwritten
    // by a push or lie beyond count.
    always_comb begin
        case (pop_n_i)
            2'd1:    shifted = {entries_q[2], entries_q[2:1]};
            2'd2:    shifted = {entries_q[2], entries_q[2], entries_q[2]};
            default: shifted = entries_q;
        endcase
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
        localparam logic [2:0] SLOT = 3'(gi);

        assign entries_d[gi] =
            ((push_n_i != 2'd0) && (SLOT == base))        ? push_hw0_i :
            ((push_n_i == 2'd2) && (SLOT == base + 3'd1)) ? push_hw1_i :
                                                            shifted[gi];
    end

    always_ff @(posedge clk) begin
        if (rst_i || clear_i) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d[1:0];
        end
    end

    // Payload needs no reset: it is only meaningful below count.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign count_o = count_q;
    assign head0_o = entries_q[0];
    assign head1_o = entries_q[1];

`ifndef SYNTHESIS
    a_count_max: assert property (@(posedge clk) disable iff (rst_i || clear_i)
        count_d <= 3'd3);
`endif

endmodule : ifetch_align_hwq

// File: rtl/ifetch_align.sv
// ----------------------------------------------------------------------------
// ifetch_align : instruction realigner between fetch and decode_decompress.
//
// Takes 32-bit word-aligned fetch words, buffers them as halfwords and emits
// whole instructions (16-bit compressed or 32-bit, possibly straddling two
// fetch words) with their address, next address and fetch fault status.
// Handshake uses prev_stalled/stall_prev towards fetch and
// next_stalled/stall_next towards decompress.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : redirect; empties the buffer, clears fault lock
//   prev_stalled          : fetch has no valid word this cycle
//   next_stalled          : decompress not accepting this cycle
//   stall_prev            : this block will not take a word this cycle
//   stall_next            : outputs are not valid this cycle
//   fetch_exception       : fetch word faulted
//   fetch_trap_cause[3:0] : fault cause of the fetch word
//   fetch_data[31:0]      : fetch word
//   fetch_addr[ALEN-1:0]  : fetch word address (bit 1 set only for a
//                           halfword redirect target)
//   ifetch_exception      : emitted instruction carries a fetch fault
//   ifetch_trap_cause[3:0]: cause of the first faulting halfword
//   instruction[ILEN-1:0] : emitted instruction
//   instruction_addr      : address of the emitted instruction
//   instruction_next_addr : address following the emitted instruction
//
// Configuration macro ISA_C_EN:
//   defined   - compressed instructions are recognised from the head opcode.
//   undefined - every head is full width; a halfword-target fetch pushes a
//               single faulting halfword with a misaligned-address cause.
// ----------------------------------------------------------------------------

module ifetch_align
    import ifetch_types::*;
    import trap_causes::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            prev_stalled,
    input  logic            next_stalled,
    output logic            stall_prev,
    output logic            stall_next,
    input  logic            fetch_exception,
    input  logic [3:0]      fetch_trap_cause,
    input  logic [31:0]     fetch_data,
    input  logic [ALEN-1:0] fetch_addr,
    output logic            ifetch_exception,
    output logic [3:0]      ifetch_trap_cause,
    output logic [ILEN-1:0] instruction,
    output logic [ALEN-1:0] instruction_addr,
    output logic [ALEN-1:0] instruction_next_addr
);

    logic [1:0]      count;
    ifetch_hw_t      head0;
    ifetch_hw_t      head1;
    logic            head_compressed;
    logic            unit1;
    logic            avail;
    logic            fire;
    logic            push;
    logic [1:0]      pop_n;
    logic [1:0]      push_n;
    logic [1:0]      count_after_pop;
    ifetch_hw_t      push_hw0;
    ifetch_hw_t      push_hw1;
    logic            lock_q;
    logic            lock_d;
    logic [ALEN-1:0] addr_q;
    logic [ALEN-1:0] addr_d;

    ifetch_align_hwq u_hwq (
        .clk        (clk),
        .rst_i      (rst),
        .clear_i    (flush),
        .push_n_i   (push_n),
        .push_hw0_i (push_hw0),
        .push_hw1_i (push_hw1),
        .pop_n_i    (pop_n),
        .count_o    (count),
        .head0_o    (head0),
        .head1_o    (head1)
    );

    // ---------------- length decode ----------------
`ifdef ISA_C_EN
    assign head_compressed = (head0.data[1:0] != 2'b11);
`else
    assign head_compressed = 1'b0;
`endif

    // A faulting head carries no trustworthy opcode, so it always leaves as
    // a 2-byte unit rather than waiting for a second halfword.
    assign unit1 = head0.exc | head_compressed;
    assign avail = ((count != 2'd0) && unit1) || (count >= 2'd2);

    // ---------------- handshake ----------------
    assign stall_next      = lock_q | ~avail;
    assign fire            = ~stall_next & ~next_stalled;
    assign pop_n           = !fire ? 2'd0 : (unit1 ? 2'd1 : 2'd2);
    assign count_after_pop = count - pop_n;
    // Accept only when the post-pop occupancy leaves room for a full word.
    // This makes next_stalled -> stall_prev combinational by design.
    assign stall_prev      = lock_q | (count_after_pop > 2'd1);
    assign push            = ~prev_stalled & ~stall_prev & ~flush;

    // ---------------- push slicing ----------------
    always_comb begin
        push_hw0 = make_hw(fetch_data[15:0], fetch_exception, fetch_trap_cause);
        push_hw1 = make_hw(fetch_data[31:16], fetch_exception, fetch_trap_cause);
        push_n   = push ? 2'd2 : 2'd0;
        if (fetch_addr[1]) begin
            // Halfword redirect target: the low half precedes the target.
            push_n = push ? 2'd1 : 2'd0;
`ifdef ISA_C_EN
            push_hw0 = make_hw(fetch_data[31:16], fetch_exception, fetch_trap_cause);
`else
            push_hw0 = make_hw(fetch_data[31:16], 1'b1, EXC_INSTR_ADDR_MISALIGNED);
`endif
        end
    end

    // ---------------- outputs ----------------
    assign instruction           = {head1.data, head0.data};
    assign instruction_addr      = addr_q;
    assign instruction_next_addr = addr_q + (unit1 ? ALEN'(2) : ALEN'(4));
    assign ifetch_exception      = unit1 ? head0.exc : (head0.exc | head1.exc);
    assign ifetch_trap_cause     = head0.exc ? head0.cause : head1.cause;

    // ---------------- head address and fault lock ----------------
    always_comb begin
        addr_d = addr_q;
        lock_d = lock_q;
        if (fire) begin
            addr_d = instruction_next_addr;
            if (ifetch_exception) begin
                lock_d = 1'b1;
            end
        end
        // The pushed word becomes the head when nothing survives the pop.
        if (push && (count_after_pop == 2'd0)) begin
            addr_d = fetch_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

`ifndef SYNTHESIS
    // Fetch must continue at the word following the buffered tail.
    a_contiguous: assert property (@(posedge clk) disable iff (rst)
        (push && (count != 2'd0)) |->
            (fetch_addr == ((addr_q + ALEN'({count, 1'b0})) & ~ALEN'(3))));
`endif

endmodule : ifetch_align

// File: tb/tb_ifetch_align.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for ifetch_align. Inputs change on the falling
// edge, outputs are sampled 1 time unit later, well away from the rising edge.
// Expected values follow the build's ISA_C_EN setting.
// ----------------------------------------------------------------------------

module tb_ifetch_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        prev_stalled;
    logic        next_stalled;
    logic        stall_prev;
    logic        stall_next;
    logic        fetch_exception;
    logic [3:0]  fetch_trap_cause;
    logic [31:0] fetch_data;
    logic [31:0] fetch_addr;
    logic        ifetch_exception;
    logic [3:0]  ifetch_trap_cause;
    logic [31:0] instruction;
    logic [31:0] instruction_addr;
    logic [31:0] instruction_next_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ifetch_align dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush                 (flush),
        .prev_stalled          (prev_stalled),
        .next_stalled          (next_stalled),
        .stall_prev            (stall_prev),
        .stall_next            (stall_next),
        .fetch_exception       (fetch_exception),
        .fetch_trap_cause      (fetch_trap_cause),
        .fetch_data            (fetch_data),
        .fetch_addr            (fetch_addr),
        .ifetch_exception      (ifetch_exception),
        .ifetch_trap_cause     (ifetch_trap_cause),
        .instruction           (instruction),
        .instruction_addr      (instruction_addr),
        .instruction_next_addr (instruction_next_addr)
    );

    // One line per instruction handed to decompress.
    always @(posedge clk) begin
        if (!rst && !stall_next && !next_stalled) begin
            $display("xfer addr=%08h next=%08h instr=%08h exc=%0b cause=%0d",
                     instruction_addr, instruction_next_addr, instruction,
                     ifetch_exception, ifetch_trap_cause);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic ps, input logic ns, input logic [31:0] d,
                         input logic [31:0] a, input logic e, input logic [3:0] c,
                         input logic fl);
        @(negedge clk);
        prev_stalled     = ps;
        next_stalled     = ns;
        fetch_data       = d;
        fetch_addr       = a;
        fetch_exception  = e;
        fetch_trap_cause = c;
        flush            = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic do_flush();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (stall_next !== 1'b1) begin failures++; $display("FAIL rst_stall_next got=%0b exp=1", stall_next); end
        checks++; if (stall_prev !== 1'b0) begin failures++; $display("FAIL rst_stall_prev got=%0b exp=0", stall_prev); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (stall_next !== 1'b1) begin failures++; $display("FAIL rst_rel_stall_next got=%0b exp=1", stall_next); end
        checks++; if (stall_prev !== 1'b0) begin failures++; $display("FAIL rst_rel_stall_prev got=%0b exp=0", stall_prev); end
    endtask

    task automatic test_full_width();
        drive(1'b0, 1'b0, 32'h00A00513, 32'h1000, 1'b0, 4'd0, 1'b0);
        checks++; if (stall_prev !== 1'b0) begin failures++; $display("FAIL fw_accept0 got=%0b exp=0", stall_prev); end
        drive(1'b0, 1'b0, 32'h00000013, 32'h1004, 1'b0, 4'd0, 1'b0);
        checks++; if (stall_next !== 1'b0) begin failures++; $display("FAIL fw_valid0 got=%0b exp=0", stall_next); end
        checks++; if (instruction !== 32'h00A00513) begin failures++; $display("FAIL fw_instr0 got=%08h exp=00a00513", instruction); end
        checks++; if (instruction_addr !== 32'h1000) begin failures++; $display("FAIL fw_addr0 got=%08h exp=00001000", instruction_addr); end
        checks++; if (instruction_next_addr !== 32'h1004) begin failures++; $display("FAIL fw_next0 got=%08h exp=00001004", instruction_next_addr); end
        checks++; if (ifetch_exception !== 1'b0) begin failures++; $display("FAIL fw_exc0 got=%0b exp=0", ifetch_exception); end
        checks++; if (stall_prev !== 1'b0) begin failures++; $display("FAIL fw_accept1 got=%0b exp=0", stall_prev); end
        idle();
        checks++; if (stall_next !== 1'b0) begin failures++; $display("FAIL fw_valid1 got=%0b exp=0", stall_next); end
        checks++; if (instruction !== 32'h00000013) begin failures++; $display("FAIL fw_instr1 got=%08h exp=00000013", instruction); end
        checks++; if (instruction_addr !== 32'h1004) begin failures++; $display("FAIL fw_addr1 got=%08h exp=00001004", instruction_addr); end
        checks++; if (instruction_next_addr !== 32'h1008) begin failures++; $display("FAIL fw_next1 got=%08h exp=00001008", instruction_next_addr); end
        idle();
        checks++; if (stall_next !== 1'b1) begin failures++; $display("FAIL fw_empty got=%0b exp=1", stall_next); end
    endtask

    task automatic test_compressed();
        logic [31:0] exp_instr;
        logic [31:0] exp_next;
        logic [31:0] got_instr;
`ifdef ISA_C_EN
        exp_instr = 32'h4501;
        exp_next  = 32'h2002;
`else
        exp_instr = 32'h05054501;
        exp_next  = 32'h2004;
`endif
        drive(1'b0, 1'b0, 32'h05054501, 32'h2000, 1'b0, 4'd0, 1'b0);
        idle();
`ifdef ISA_C_EN
        got_instr = {16'h0, instruction[15:0]};
`else
        got_instr = instruction;
`endif
        checks++; if (stall_next !== 1'b0) begin failures++; $display("FAIL c_valid0 got=%0b exp=0", stall_next); end
        checks++; if (got_instr !== exp_instr) begin failures++; $display("FAIL c_instr0 got=%08h exp=%08h", got_instr, exp_instr); end
        checks++; if (instruction_addr !== 32'h2000) begin failures++; $display("FAIL c_addr0 got=%08h exp=00002000", instruction_addr); end
        checks++; if (instruction_next_addr !== exp_next) begin failures++; $display("FAIL c_next0 got=%08h exp=%08h", instruction_next_addr, exp_next); end
        idle();
`ifdef ISA_C_EN
        checks++; if (stall_next !== 1'b0) begin failures++; $display("FAIL c_valid1 got=%0b exp=0", stall_next); end
        checks++; if (instruction[15:0] !== 16'h0505) begin failures++; $display("FAIL c_instr1 got=%04h exp=0505", instruction[15:0]); end
        checks++; if (instruction_addr !== 32'h2002) begin failures++; $display("FAIL c_addr1 got=%08h exp=00002002", instruction_addr); end
        checks++; if (instruction_next_addr !== 32'h2004) begin failures++; $display("FAIL c_next1 got=%08h exp=00002004", instruction_next_addr); end
        idle();
`endif
        checks++; if (stall_next !== 1'b1) begin failures++; $display("FAIL c_empty got=%0b exp=1", stall_next); end
    endtask

    task automatic test_straddle();
        drive(1'b0, 1'b0, 32'h05134501, 32'h3000, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 32'hBEEF00A0, 32'h3004, 1'b0, 4'd0, 1'b0);
        checks++; if (stall_prev !== 1'b0) begin failures++; $display("FAIL st_accept got=%0b exp=0", stall_prev); end
        checks++; if (instruction_addr !== 32'h3000) begin failures++; $display("FAIL st_addr0 got=%08h exp=00003000", instruction_addr); end
`ifdef ISA_C_EN
        checks++; if (instruction[15:0] !== 16'h4501) begin failures++; $display("FAIL st_instr0 got=%04h exp=4501", instruction[15:0]); end
        checks++; if (instruction_next_addr !== 32'h3002) begin failures++; $display("FAIL st_next0 got=%08h exp=00003002", instruction_next_addr); end
`else
        checks++; if (instruction !== 32'h05134501) begin failures++; $display("FAIL st_instr0 got=%08h exp=05134501", instruction); end
        checks++; if (instruction_next_addr !== 32'h3004) begin failures++; $display("FAIL st_next0 got=%08h exp=00003004", instruction_next_addr); end
`endif
        idle();
        checks++; if (stall_next !== 1'b0) begin failures++; $display("FAIL st_valid1 got=%0b exp=0", stall_next); end
`ifdef ISA_C_EN
        checks++; if (instruction !== 32'h00A00513) begin failures++; $display("FAIL st_instr1 got=%08h exp=00a00513", instruction); end
        checks++; if (instruction_addr !== 32'h3002) begin failures++; $display("FAIL st_addr1 got=%08h exp=00003002", instruction_addr); end
        checks++; if (instruction_next_addr !== 32'h3006) begin failures++; $display("FAIL st_next1 got=%08h exp=00003006", instruction_next_addr); end
`else
        checks++; if (instruction !== 32'hBEEF00A0) begin failures++; $display("FAIL st_instr1 got=%08h exp=beef00a0", instruction); end
        checks++; if (instruction_addr !== 32'h3004) begin failures++; $display("FAIL st_addr1 got=%08h exp=00003004", instruction_addr); end
        checks++; if (instruction_next_addr !== 32'h3008) begin failures++; $display("FAIL st_next1 got=%08h exp=00003008", instruction_next_addr); end
`endif
        idle();
        // A lone full-width halfword (or nothing) remains: not emittable.
        checks++; if (stall_next !== 1'b1) begin failures++; $display("FAIL st_partial got=%0b exp=1", stall_next); end
        do_flush();
    endtask

    task automatic test_halfword_target();
        logic exp_exc;
        logic exp_lock;
`ifdef ISA_C_EN
        exp_exc  = 1'b0;
        exp_lock = 1'b0;
`else
        exp_exc  = 1'b1;
        exp_lock = 1'b1;
`endif
        // A word offered during flush must be dropped.
        drive(1'b0, 1'b0, 32'h00A00513, 32'h7000, 1'b0, 4'd0, 1'b1);
        drive(1'b0, 1'b0, 32'h45051234, 32'h4002, 1'b0, 4'd0, 1'b0);
        checks++; if (stall_next !== 1'b1) begin failures++; $display("FAIL hw_flush_drop got=%0b exp=1", stall_next); end
        checks++; if (stall_prev !== 1'b0) begin failures++; $display("FAIL hw_accept got=%0b exp=0", stall_prev); end
        idle();
        checks++; if (stall_next !== 1'b0) begin failures++; $display("FAIL hw_valid got=%0b exp=0", stall_next); end
        checks++; if (instruction[15:0] !== 16'h4505) begin failures++; $display("FAIL hw_instr got=%04h exp=4505", instruction[15:0]); end
        checks++; if (instruction_addr !== 32'h4002) begin failures++; $display("FAIL hw_addr got=%08h exp=00004002", instruction_addr); end
        checks++; if (instruction_next_addr !== 32'h4004) begin failures++; $display("FAIL hw_next got=%08h exp=00004004", instruction_next_addr); end
        checks++; if (ifetch_exception !== exp_exc) begin failures++; $display("FAIL hw_exc got=%0b exp=%0b", ifetch_exception, exp_exc); end
`ifndef ISA_C_EN
        checks++; if (ifetch_trap_cause !== 4'd0) begin failures++; $display("FAIL hw_cause got=%0d exp=0", ifetch_trap_cause); end
`endif
        idle();
        checks++; if (stall_next !== 1'b1) begin failures++; $display("FAIL hw_empty got=%0b exp=1", stall_next); end
        checks++; if (stall_prev !== exp_lock) begin failures++; $display("FAIL hw_lock got=%0b exp=%0b", stall_prev, exp_lock); end
        do_flush();
        idle();
        checks++; if (stall_prev !== 1'b0) begin failures++; $display("FAIL hw_unlock got=%0b exp=0", stall_prev); end
    endtask

    task automatic test_fault_lock();
        logic [31:0] exp_addr;
`ifdef ISA_C_EN
        exp_addr = 32'h5002;
`else
        exp_addr = 32'h5004;
`endif
        drive(1'b0, 1'b0, 32'h05134501, 32'h5000, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 32'h00000000, 32'h5004, 1'b1, 4'd12, 1'b0);
        checks++; if (stall_prev !== 1'b0) begin failures++; $display("FAIL fl_accept got=%0b exp=0", stall_prev); end
        checks++; if (ifetch_exception !== 1'b0) begin failures++; $display("FAIL fl_exc0 got=%0b exp=0", ifetch_exception); end
        idle();
        checks++; if (stall_next !== 1'b0) begin failures++; $display("FAIL fl_valid got=%0b exp=0", stall_next); end
        checks++; if (ifetch_exception !== 1'b1) begin failures++; $display("FAIL fl_exc1 got=%0b exp=1", ifetch_exception); end
        checks++; if (ifetch_trap_cause !== 4'd12) begin failures++; $display("FAIL fl_cause got=%0d exp=12", ifetch_trap_cause); end
        checks++; if (instruction_addr !== exp_addr) begin failures++; $display("FAIL fl_addr got=%08h exp=%08h", instruction_addr, exp_addr); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h00000013, 32'h5008, 1'b0, 4'd0, 1'b0);
            checks++; if (stall_next !== 1'b1) begin failures++; $display("FAIL fl_hold_next[%0d] got=%0b exp=1", i, stall_next); end
            checks++; if (stall_prev !== 1'b1) begin failures++; $display("FAIL fl_hold_prev[%0d] got=%0b exp=1", i, stall_prev); end
        end
        drive(1'b0, 1'b0, 32'h00000013, 32'h5008, 1'b0, 4'd0, 1'b1);
        idle();
        checks++; if (stall_next !== 1'b1) begin failures++; $display("FAIL fl_post_next got=%0b exp=1", stall_next); end
        checks++; if (stall_prev !== 1'b0) begin failures++; $display("FAIL fl_post_prev got=%0b exp=0", stall_prev); end
    endtask

    task automatic test_backpressure();
`ifdef ISA_C_EN
        drive(1'b0, 1'b1, 32'h05134501, 32'h6000, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 32'h450500A0, 32'h6004, 1'b0, 4'd0, 1'b0);
        checks++; if (stall_prev !== 1'b0) begin failures++; $display("FAIL bp_accept1 got=%0b exp=0", stall_prev); end
        checks++; if (instruction[15:0] !== 16'h4501) begin failures++; $display("FAIL bp_instr0 got=%04h exp=4501", instruction[15:0]); end
        // Queue now holds three halfwords; hold decompress off.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 32'h00A00513, 32'h6008, 1'b0, 4'd0, 1'b0);
            checks++; if (stall_prev !== 1'b1) begin failures++; $display("FAIL bp_full_prev[%0d] got=%0b exp=1", i, stall_prev); end
            checks++; if (stall_next !== 1'b0) begin failures++; $display("FAIL bp_full_next[%0d] got=%0b exp=0", i, stall_next); end
            checks++; if (instruction !== 32'h00A00513) begin failures++; $display("FAIL bp_hold_instr[%0d] got=%08h exp=00a00513", i, instruction); end
            checks++; if (instruction_addr !== 32'h6002) begin failures++; $display("FAIL bp_hold_addr[%0d] got=%08h exp=00006002", i, instruction_addr); end
        end
        drive(1'b0, 1'b0, 32'h00A00513, 32'h6008, 1'b0, 4'd0, 1'b0);
        checks++; if (stall_prev !== 1'b0) begin failures++; $display("FAIL bp_release got=%0b exp=0", stall_prev); end
        checks++; if (instruction_next_addr !== 32'h6006) begin failures++; $display("FAIL bp_next1 got=%08h exp=00006006", instruction_next_addr); end
        idle();
        checks++; if (instruction[15:0] !== 16'h4505) begin failures++; $display("FAIL bp_instr2 got=%04h exp=4505", instruction[15:0]); end
        checks++; if (instruction_addr !== 32'h6006) begin failures++; $display("FAIL bp_addr2 got=%08h exp=00006006", instruction_addr); end
        checks++; if (stall_prev !== 1'b1) begin failures++; $display("FAIL bp_after_pop1 got=%0b exp=1", stall_prev); end
        idle();
        checks++; if (instruction !== 32'h00A00513) begin failures++; $display("FAIL bp_instr3 got=%08h exp=00a00513", instruction); end
        checks++; if (instruction_addr !== 32'h6008) begin failures++; $display("FAIL bp_addr3 got=%08h exp=00006008", instruction_addr); end
        checks++; if (instruction_next_addr !== 32'h600C) begin failures++; $display("FAIL bp_next3 got=%08h exp=0000600c", instruction_next_addr); end
`else
        drive(1'b0, 1'b1, 32'h05134501, 32'h6000, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 32'h00A00513, 32'h6004, 1'b0, 4'd0, 1'b0);
            checks++; if (stall_prev !== 1'b1) begin failures++; $display("FAIL bp_full_prev[%0d] got=%0b exp=1", i, stall_prev); end
            checks++; if (stall_next !== 1'b0) begin failures++; $display("FAIL bp_full_next[%0d] got=%0b exp=0", i, stall_next); end
            checks++; if (instruction !== 32'h05134501) begin failures++; $display("FAIL bp_hold_instr[%0d] got=%08h exp=05134501", i, instruction); end
            checks++; if (instruction_addr !== 32'h6000) begin failures++; $display("FAIL bp_hold_addr[%0d] got=%08h exp=00006000", i, instruction_addr); end
        end
        drive(1'b0, 1'b0, 32'h00A00513, 32'h6004, 1'b0, 4'd0, 1'b0);
        checks++; if (stall_prev !== 1'b0) begin failures++; $display("FAIL bp_release got=%0b exp=0", stall_prev); end
        idle();
        checks++; if (instruction !== 32'h00A00513) begin failures++; $display("FAIL bp_instr1 got=%08h exp=00a00513", instruction); end
        checks++; if (instruction_addr !== 32'h6004) begin failures++; $display("FAIL bp_addr1 got=%08h exp=00006004", instruction_addr); end
        checks++; if (instruction_next_addr !== 32'h6008) begin failures++; $display("FAIL bp_next1 got=%08h exp=00006008", instruction_next_addr); end
`endif
        idle();
        checks++; if (stall_next !== 1'b1) begin failures++; $display("FAIL bp_empty got=%0b exp=1", stall_next); end
    endtask

    initial begin
        rst              = 1'b1;
        flush            = 1'b0;
        prev_stalled     = 1'b1;
        next_stalled     = 1'b0;
        fetch_exception  = 1'b0;
        fetch_trap_cause = 4'd0;
        fetch_data       = 32'h0;
        fetch_addr       = 32'h0;
        test_reset();
        test_full_width();
        test_compressed();
        test_straddle();
        test_halfword_target();
        test_fault_lock();
        test_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ifetch_align
